// File: rtl/sd_read_scheduler.sv
// Arbitrates 512-byte SD sector reads among two audio refills and the tile loader,
// launches each read and steers returned bytes, with their index, to the owner's buffer.
module sd_read_scheduler #(
  parameter int SECTOR_BYTES   = 512,
  parameter int ADDR_W         = 24,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [2:0]                    req_i,
  input  logic [3*ADDR_W-1:0]           req_addr_i,
  input  logic                          sd_byte_valid_i,
  input  logic [7:0]                    sd_byte_i,
  output logic [ADDR_W-1:0]             sd_input_address_o,
  output logic                          sd_read_start_o,
  output logic [2:0]                    grant_o,
  output logic                          wr_en_o,
  output logic [1:0]                    wr_sel_o,
  output logic [$clog2(SECTOR_BYTES)-1:0] wr_addr_o,
  output logic [7:0]                    wr_data_o,
  output logic [2:0]                    done_o,
  output logic [2:0]                    error_o,
  output logic [1:0]                    state_o
);

  localparam int CNT_W = $clog2(SECTOR_BYTES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(SECTOR_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ST_W-1:0]  ST_LIMIT  = ST_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, STREAM, FINISH} state_t;

  state_t             state_q, state_d;
  logic [2:0]         grant_q, grant_d;
  logic [1:0]         sel_q, sel_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               start_q, start_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               rr_q, rr_d;
  logic [ST_W-1:0]    starve_q, starve_d;
  logic               wr_en_q, wr_en_d;
  logic [1:0]         wr_sel_q, wr_sel_d;
  logic [CNT_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic [2:0]         done_q, done_d;
  logic [2:0]         error_q, error_d;
  logic [1:0]         win;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      sel_q      <= '0;
      addr_q     <= '0;
      start_q    <= 1'b0;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
      rr_q       <= 1'b0;
      starve_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_sel_q   <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= '0;
      error_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      start_q    <= start_d;
      byte_cnt_q <= byte_cnt_d;
      to_cnt_q   <= to_cnt_d;
      rr_q       <= rr_d;
      starve_q   <= starve_d;
      wr_en_q    <= wr_en_d;
      wr_sel_q   <= wr_sel_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    start_d    = 1'b0;
    byte_cnt_d = byte_cnt_q;
    to_cnt_d   = to_cnt_q;
    rr_d       = rr_q;
    starve_d   = starve_q;
    wr_en_d    = 1'b0;
    wr_sel_d   = wr_sel_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = '0;
    error_d    = '0;
    win        = 2'd0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          // Tiles only beat pending audio once audio has taken STARVE_LIMIT grants in a row.
          if (req_i[2] && (!(req_i[0] || req_i[1]) || starve_q == ST_LIMIT)) begin
            win      = 2'd2;
            starve_d = '0;
          end else begin
            if (req_i[0] && req_i[1]) win = {1'b0, rr_q};
            else                      win = req_i[0] ? 2'd0 : 2'd1;
            rr_d     = ~win[0];
            starve_d = req_i[2] ? starve_q + 1'b1 : '0;
          end
          sel_d   = win;
          grant_d = 3'b001 << win;
          addr_d  = req_addr_i[32'(win)*ADDR_W +: ADDR_W];
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        byte_cnt_d = '0;
        to_cnt_d   = '0;
        state_d    = STREAM;
      end
      STREAM: begin
        if (sd_byte_valid_i) begin
          wr_en_d    = 1'b1;
          wr_sel_d   = sel_q;
          wr_addr_d  = byte_cnt_q;
          wr_data_d  = sd_byte_i;
          byte_cnt_d = byte_cnt_q + 1'b1;
          to_cnt_d   = '0;
          if (byte_cnt_q == LAST_BYTE) begin
            done_d  = grant_q;
            state_d = FINISH;
          end
        end else if (to_cnt_q == TO_LAST) begin
          error_d = grant_q;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      FINISH: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sd_input_address_o = addr_q;
  assign sd_read_start_o    = start_q;
  assign grant_o            = grant_q;
  assign wr_en_o            = wr_en_q;
  assign wr_sel_o           = wr_sel_q;
  assign wr_addr_o          = wr_addr_q;
  assign wr_data_o          = wr_data_q;
  assign done_o             = done_q;
  assign error_o            = error_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_sd_read_scheduler.sv
// Bench for sd_read_scheduler: random byte timing/data, arbitration reference model,
// expected-queue scoreboard checked by an independent monitor.
module tb_sd_read_scheduler;
  localparam int SB   = 512;
  localparam int AW   = 24;
  localparam int TO   = 50;
  localparam int SL   = 4;
  localparam int CW   = 9;
  localparam int WR_W = 2 + CW + 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [2:0]        req_i;
  logic [3*AW-1:0]   req_addr_i;
  logic              sd_byte_valid_i;
  logic [7:0]        sd_byte_i;
  logic [AW-1:0]     sd_input_address_o;
  logic              sd_read_start_o;
  logic [2:0]        grant_o;
  logic              wr_en_o;
  logic [1:0]        wr_sel_o;
  logic [CW-1:0]     wr_addr_o;
  logic [7:0]        wr_data_o;
  logic [2:0]        done_o;
  logic [2:0]        error_o;
  logic [1:0]        state_o;

  // clock / reset
  always #5 clk_i = ~clk_i;

  sd_read_scheduler #(
    .SECTOR_BYTES(SB), .ADDR_W(AW), .TIMEOUT_CYCLES(TO), .STARVE_LIMIT(SL)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .req_addr_i(req_addr_i),
    .sd_byte_valid_i(sd_byte_valid_i), .sd_byte_i(sd_byte_i),
    .sd_input_address_o(sd_input_address_o), .sd_read_start_o(sd_read_start_o),
    .grant_o(grant_o), .wr_en_o(wr_en_o), .wr_sel_o(wr_sel_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .done_o(done_o), .error_o(error_o), .state_o(state_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [WR_W-1:0] exp_q[$];
  logic [AW+2:0]   exp_gnt_q[$];
  logic [5:0]      exp_ev_q[$];
  logic [AW-1:0]   addr_a[3];

  // arbitration reference: which track is next in turn, and audio grants since tiles last won
  int m_next_track = 0;
  int m_streak     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic predict(input logic [2:0] r, output int win);
    bit audio;
    audio = r[0] || r[1];
    if (r[2] && (!audio || m_streak == SL)) begin
      win = 2;
      m_streak = 0;
    end else begin
      if (r[0] && r[1]) win = m_next_track;
      else              win = r[0] ? 0 : 1;
      m_next_track = 1 - win;
      m_streak = r[2] ? m_streak + 1 : 0;
    end
  endtask

  task automatic set_addrs();
    req_addr_i = {addr_a[2], addr_a[1], addr_a[0]};
  endtask

  task automatic request(output int win);
    logic [2:0] g;
    predict(req_i, win);
    g = 3'b001 << win;
    exp_gnt_q.push_back({g, addr_a[win]});
  endtask

  task automatic wait_start(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk_i);
      cyc++;
    end while (!sd_read_start_o && cyc < 300);
    if (!sd_read_start_o) chk("start_wait_expired", 64'(cyc), 0);
  endtask

  task automatic stream(input int n, input int sel, input bit ramp, input int drop_at);
    logic [7:0] b;
    @(negedge clk_i);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (i == drop_at) req_i[sel] = 1'b0;
      sd_byte_valid_i = 1'b0;
      repeat (gap) @(negedge clk_i);
      b = ramp ? 8'(i) : 8'($urandom);
      sd_byte_valid_i = 1'b1;
      sd_byte_i = b;
      exp_q.push_back({2'(sel), CW'(i), b});
      @(negedge clk_i);
    end
    sd_byte_valid_i = 1'b0;
  endtask

  task automatic do_xfer(input bit ramp, input int drop_at, output int win, output int cyc);
    logic [2:0] g;
    request(win);
    wait_start(cyc);
    g = 3'b001 << win;
    exp_ev_q.push_back({g, 3'b000});
    stream(SB, win, ramp, drop_at);
  endtask

  // monitor / scoreboard
  logic            prev_start = 1'b0;
  logic [WR_W-1:0] m_wr;
  logic [AW+2:0]   m_gnt;
  logic [5:0]      m_ev;

  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_start = 1'b0;
    end else begin
      if (wr_en_o) begin
        if (exp_q.size() == 0) chk("unexpected_wren", 64'(wr_en_o), 0);
        else begin
          m_wr = exp_q.pop_front();
          chk("write_sel_addr_data", {wr_sel_o, wr_addr_o, wr_data_o}, m_wr);
        end
      end
      if (sd_read_start_o) begin
        if (prev_start) chk("start_pulse_width", 64'(prev_start), 0);
        else if (exp_gnt_q.size() == 0) chk("unexpected_start", 64'(sd_read_start_o), 0);
        else begin
          m_gnt = exp_gnt_q.pop_front();
          chk("grant_and_address", {grant_o, sd_input_address_o}, m_gnt);
        end
      end
      prev_start = sd_read_start_o;
      if (done_o != 3'b000 || error_o != 3'b000) begin
        chk("done_error_exclusive",
            64'(($onehot(done_o) && error_o == 3'b000) || ($onehot(error_o) && done_o == 3'b000)), 1);
        if (exp_ev_q.size() == 0) chk("unexpected_done_error", {done_o, error_o}, 0);
        else begin
          m_ev = exp_ev_q.pop_front();
          chk("done_error_bits", {done_o, error_o}, m_ev);
        end
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk_i);
    chk("watchdog_expired", 1, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // main stimulus
  initial begin
    int win, cyc, n;
    rst_i = 1'b1;
    req_i = 3'b000;
    sd_byte_valid_i = 1'b0;
    sd_byte_i = 8'h00;
    addr_a[0] = 24'h000028;
    addr_a[1] = 24'($urandom);
    addr_a[2] = 24'($urandom);
    set_addrs();
    repeat (3) @(negedge clk_i);
    chk("rst_grant", grant_o, 0);
    chk("rst_start", sd_read_start_o, 0);
    chk("rst_wr_en", wr_en_o, 0);
    chk("rst_wr_sel", wr_sel_o, 0);
    chk("rst_wr_addr", wr_addr_o, 0);
    chk("rst_wr_data", wr_data_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_address", sd_input_address_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // single track1 read with ramp data
    req_i = 3'b001;
    do_xfer(1'b1, -1, win, cyc);
    chk("first_start_latency", 64'(cyc), 1);
    req_i = 3'b000;

    // both audio tracks held: alternate with one idle cycle between transfers
    addr_a[0] = 24'($urandom);
    set_addrs();
    req_i = 3'b011;
    for (int k = 0; k < 4; k++) begin
      do_xfer(1'b0, -1, win, cyc);
      if (k > 0) chk("back_to_back_gap", 64'(cyc), 2);
    end
    req_i = 3'b000;

    // all three held: tiles win after the starvation limit
    for (int r = 0; r < 3; r++) addr_a[r] = 24'($urandom);
    set_addrs();
    req_i = 3'b111;
    for (int k = 0; k < 6; k++) do_xfer(1'b0, -1, win, cyc);
    req_i = 3'b000;

    // stall after 100 bytes: timeout abort
    req_i = 3'b001;
    request(win);
    wait_start(cyc);
    exp_ev_q.push_back({3'b000, 3'b001});
    stream(100, 0, 1'b0, -1);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (error_o == 3'b000 && n < 200);
    chk("timeout_latency", 64'(n), TO);
    chk("timeout_grant_cleared", grant_o, 0);
    req_i = 3'b000;
    @(negedge clk_i);
    req_i = 3'b010;
    do_xfer(1'b0, -1, win, cyc);
    req_i = 3'b000;

    // asynchronous reset in the middle of a transfer
    req_i = 3'b100;
    request(win);
    wait_start(cyc);
    stream(300, win, 1'b0, -1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("midrst_grant", grant_o, 0);
    chk("midrst_wr_en", wr_en_o, 0);
    chk("midrst_wr_addr", wr_addr_o, 0);
    chk("midrst_done_error", {done_o, error_o}, 0);
    chk("midrst_address", sd_input_address_o, 0);
    req_i = 3'b000;
    m_next_track = 0;
    m_streak = 0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    req_i = 3'b011;
    do_xfer(1'b0, -1, win, cyc);
    req_i = 3'b000;

    // requester drops early, then a stray byte while idle
    req_i = 3'b001;
    do_xfer(1'b0, 10, win, cyc);
    req_i = 3'b000;
    @(negedge clk_i);
    sd_byte_valid_i = 1'b1;
    sd_byte_i = 8'($urandom);
    @(negedge clk_i);
    sd_byte_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stray_byte_no_wren", wr_en_o, 0);
      @(negedge clk_i);
    end

    repeat (5) @(negedge clk_i);
    chk("scoreboard_drained", 64'(exp_q.size() + exp_gnt_q.size() + exp_ev_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
